// File: rtl/pipe_buf.sv
// Elastic register pipeline with per-stage valid bits: stages advance when empty or when the
// stage downstream advances, so bubbles collapse while stalled. Flush and reset both empty it.
module pipe_buf #(
    parameter int               WIDTH = 32,
    parameter int               DEPTH = 2,
    parameter logic [0:WIDTH-1] RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:WIDTH-1] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] dout,
    output logic [3:0]       occupancy
);
    logic [0:WIDTH-1] data_q [DEPTH];
    logic [0:WIDTH-1] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d, adv;
    logic [3:0]       occ_q, occ_d;
    logic             kill, accept, pop, chain;

    assign kill = rst | flush;

    // A stage advances if out_ready is high or any stage from it to the output is empty.
    always_comb begin
        chain = out_ready;
        adv   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain  = chain | ~vld_q[i];
            adv[i] = chain;
        end
    end

    assign in_ready = adv[0] & ~kill;
    assign accept   = in_valid & in_ready;
    assign pop      = vld_q[DEPTH-1] & out_ready & ~kill;

    // Data registers only load when a valid word moves into them.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (adv[0]) begin
            vld_d[0] = accept;
            if (accept) data_d[0] = din;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i]) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) data_d[i] = data_q[i-1];
            end
        end
    end

    always_comb begin
        case ({accept, pop})
            2'b10:   occ_d = occ_q + 4'd1;
            2'b01:   occ_d = occ_q - 4'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            vld_q <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET;
        end else begin
            vld_q <= vld_d;
            occ_q <= occ_d;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign dout      = data_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_buf.sv
// Bench for pipe_buf: a DEPTH=3 and a DEPTH=1 instance, scoreboard queues of accepted words
// checked against popped words, plus cycle-exact checks of latency, stall, reset and flush.
module tb_pipe_buf;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush;
    logic       in_valid, out_ready, in_ready, out_valid;
    logic [0:7] din, dout;
    logic [3:0] occupancy;
    logic       in_valid1, out_ready1, in_ready1, out_valid1;
    logic [0:7] din1, dout1;
    logic [3:0] occupancy1;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] sb[$];
    logic [7:0] sb1[$];
    logic [7:0] exp_w;

    pipe_buf #(.WIDTH(8), .DEPTH(3), .RESET(8'h5A)) dut3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .occupancy(occupancy)
    );

    pipe_buf #(.WIDTH(8), .DEPTH(1), .RESET(8'h5A)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid1), .in_ready(in_ready1),
        .din(din1), .out_valid(out_valid1), .out_ready(out_ready1), .dout(dout1),
        .occupancy(occupancy1)
    );

    // Apply one cycle of stimulus after the falling edge, then record accepted words.
    task automatic drive(input logic v, input logic [7:0] d, input logic ordy,
                         input logic fl, input logic r);
        @(negedge clk);
        in_valid = v; din = d; out_ready = ordy; flush = fl; rst = r;
        #1;
        if (in_valid && in_ready) sb.push_back(din);
    endtask

    task automatic drive1(input logic v, input logic [7:0] d, input logic ordy);
        @(negedge clk);
        in_valid1 = v; din1 = d; out_ready1 = ordy; flush = 1'b0; rst = 1'b0;
        #1;
        if (in_valid1 && in_ready1) sb1.push_back(din1);
    endtask

    task automatic test_reset();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready_during: got %b want 0", in_ready); end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (dout !== 8'h5A) begin n_bad++; $display("FAIL reset_dout: got %h want 5a", dout); end
        n_cmp++; if (occupancy !== 4'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready); end
    endtask

    task automatic test_streaming();
        logic [7:0] d[3];
        int k;
        d = '{8'h11, 8'h22, 8'h33};
        k = 0;
        for (int c = 0; c < 10; c++) begin
            drive(c < 3, (c < 3) ? d[c] : 8'h00, 1'b1, 1'b0, 1'b0);
            if (c < 3) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready c%0d: got %b want 1", c, in_ready); end
            end
            if (out_valid && out_ready) begin
                exp_w = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                n_cmp++; if (dout !== exp_w) begin n_bad++; $display("FAIL stream_data: got %h want %h", dout, exp_w); end
                n_cmp++; if (c !== 3 + k) begin n_bad++; $display("FAIL stream_latency: word %0d at cycle %0d want %0d", k, c, 3 + k); end
                k++;
            end
        end
        n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL stream_count: got %0d want 3", k); end
    endtask

    task automatic test_backpressure();
        logic [7:0] items[4];
        int idx, k;
        items = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        idx = 0; k = 0;
        for (int c = 0; c < 16; c++) begin
            drive(idx < 4, (idx < 4) ? items[idx] : 8'h00, c >= 6, 1'b0, 1'b0);
            if (in_valid && in_ready) idx++;
            if (c >= 3 && c <= 5) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
                n_cmp++; if (occupancy !== 4'd3) begin n_bad++; $display("FAIL bp_occ c%0d: got %0d want 3", c, occupancy); end
            end
            if (out_valid && out_ready) begin
                exp_w = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                n_cmp++; if (dout !== items[k]) begin n_bad++; $display("FAIL bp_order: got %h want %h", dout, items[k]); end
                n_cmp++; if (dout !== exp_w) begin n_bad++; $display("FAIL bp_scoreboard: got %h want %h", dout, exp_w); end
                k++;
            end
        end
        n_cmp++; if (k !== 4) begin n_bad++; $display("FAIL bp_count: got %0d want 4", k); end
    endtask

    task automatic test_bubble();
        for (int c = 0; c < 7; c++) begin
            drive(c == 0, 8'h77, 1'b0, 1'b0, 1'b0);
            if (c >= 1) begin
                n_cmp++; if (occupancy !== 4'd1) begin n_bad++; $display("FAIL bubble_occ c%0d: got %0d want 1", c, occupancy); end
            end
            n_cmp++; if (out_valid !== (c >= 3)) begin n_bad++; $display("FAIL bubble_valid c%0d: got %b want %b", c, out_valid, c >= 3); end
            if (c >= 3) begin
                n_cmp++; if (dout !== 8'h77) begin n_bad++; $display("FAIL bubble_dout c%0d: got %h want 77", c, dout); end
            end
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        exp_w = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_cmp++; if (!(out_valid === 1'b1 && dout === exp_w)) begin n_bad++; $display("FAIL bubble_pop: got %b/%h want 1/%h", out_valid, dout, exp_w); end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (occupancy !== 4'd2) begin n_bad++; $display("FAIL mid_occ_before: got %0d want 2", occupancy); end
        drive(1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
        sb.delete();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (dout !== 8'h5A) begin n_bad++; $display("FAIL mid_dout: got %h want 5a", dout); end
        n_cmp++; if (occupancy !== 4'd0) begin n_bad++; $display("FAIL mid_occ: got %0d want 0", occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) drive(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (occupancy !== 4'd3) begin n_bad++; $display("FAIL flush_occ_before: got %0d want 3", occupancy); end
        drive(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        sb.delete();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (occupancy !== 4'd0) begin n_bad++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (dout !== 8'h5A) begin n_bad++; $display("FAIL flush_dout: got %h want 5a", dout); end
    endtask

    task automatic test_depth1();
        int k;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            drive1(c < 10, 8'hC0 + 8'(c), 1'b1);
            if (c < 10) begin
                n_cmp++; if (in_ready1 !== 1'b1) begin n_bad++; $display("FAIL d1_in_ready c%0d: got %b want 1", c, in_ready1); end
            end
            if (c >= 1 && c <= 10) begin
                n_cmp++; if (occupancy1 !== 4'd1) begin n_bad++; $display("FAIL d1_occ c%0d: got %0d want 1", c, occupancy1); end
            end
            if (out_valid1 && out_ready1) begin
                exp_w = (sb1.size() > 0) ? sb1.pop_front() : 8'hxx;
                n_cmp++; if (dout1 !== exp_w) begin n_bad++; $display("FAIL d1_data: got %h want %h", dout1, exp_w); end
                n_cmp++; if (c !== k + 1) begin n_bad++; $display("FAIL d1_latency: word %0d at cycle %0d want %0d", k, c, k + 1); end
                k++;
            end
        end
        n_cmp++; if (k !== 10) begin n_bad++; $display("FAIL d1_count: got %0d want 10", k); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din = 8'h00;
        in_valid1 = 1'b0; out_ready1 = 1'b1; din1 = 8'h00;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_reset_midstream();
        test_flush();
        test_depth1();
        n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pipe_buf.md
PIPE_BUF -- requirements
Module: pipe_buf

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data width in bits, legal range 1..64.
REQ-002 SHALL provide parameter DEPTH, default 2, number of register stages, legal range 1..15.
REQ-003 SHALL provide parameter RESET, default 0, value loaded into every data stage on reset or flush.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous discard of all held words, for pipeline kill.
REQ-007 SHALL have port in_valid  input  1  producer offers din this cycle.
REQ-008 SHALL have port in_ready  output  1  buffer accepts din this cycle.
REQ-009 SHALL have port din  input  [0:WIDTH-1]  input word, bit 0 is MSB.
REQ-010 SHALL have port out_valid  output  1  dout holds a valid word.
REQ-011 SHALL have port out_ready  input  1  consumer takes dout this cycle.
REQ-012 SHALL have port dout  output  [0:WIDTH-1]  data of last stage, bit 0 is MSB.
REQ-013 SHALL have port occupancy  output  4  count of valid stages, 0..DEPTH.

Function
REQ-014 SHALL hold DEPTH stages, each a WIDTH data register plus valid bit; stage DEPTH-1 drives dout/out_valid.
REQ-015 SHALL define accept = in_valid && in_ready and pop = out_valid && out_ready.
REQ-016 SHALL advance stage DEPTH-1 when empty or popped; stage i<DEPTH-1 advances when empty or stage i+1 advances (bubble collapse).
REQ-017 SHALL drive in_ready = advance of stage 0, combinationally; in_ready may depend on out_ready.
REQ-018 SHALL, when a stage advances, load data/valid of the preceding stage (stage 0 loads din/accept); a stage not advancing holds.
REQ-019 SHALL give latency exactly DEPTH cycles from accept cycle to out_valid cycle with empty buffer and out_ready=1.
REQ-020 SHALL sustain one accept and one pop per cycle when full and out_ready=1; occupancy unchanged.
REQ-021 SHALL keep dout and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL preserve order; no word lost or duplicated.
REQ-023 SHALL update occupancy registered: +1 on accept only, -1 on pop only, unchanged on both or neither.
REQ-024 SHALL not load data registers of invalid words except on rst/flush; dout content with out_valid=0 is don't-care except after rst/flush (RESET).
REQ-025 SHALL, on flush=1, clear all valid bits, load RESET into all data stages, zero occupancy at next edge; in_ready=0 during flush, so same-cycle din is discarded and no pop occurs.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, clear all valid bits, load RESET into every data stage, zero occupancy.
REQ-027 SHALL give rst priority over flush, in_valid and out_ready; in_ready=0 while rst=1.
REQ-028 SHALL, in the first cycle after rst deasserts, show out_valid=0, dout=RESET, occupancy=0, in_ready=1.

Verification (WIDTH=8, DEPTH=3, RESET=8'h5A unless stated)
REQ-029 SHALL cover reset mid-stream: occupancy 2, assert rst one cycle -> next cycle out_valid=0, dout=8'h5A, occupancy=0, in_ready=1.
REQ-030 SHALL cover streaming: out_ready=1, push 8'h11,8'h22,8'h33 in consecutive cycles -> out_valid cycles 3,4,5 with 8'h11,8'h22,8'h33; in_ready stays 1.
REQ-031 SHALL cover backpressure: out_ready=0, offer 8'hA1..8'hA4 -> A1..A3 accepted, in_ready=0 at occupancy 3, A4 held; raise out_ready -> A1,A2,A3,A4 out in order.
REQ-032 SHALL cover bubble collapse: out_ready=0, one push of 8'h77 at cycle 0 -> out_valid=1, dout=8'h77 from cycle 3, stable while stalled; occupancy 1.
REQ-033 SHALL cover flush: occupancy 3, flush=1 with in_valid=1, din=8'hEE, out_ready=1 -> no pop, 8'hEE dropped; next cycle occupancy 0, out_valid=0, dout=8'h5A.
REQ-034 SHALL cover DEPTH=1 full-throughput: out_ready=1, continuous pushes -> one word per cycle, 1-cycle latency, occupancy stays 1.
